// File: rtl/truth_table_extractor.sv
// ---------------------------------------------------------------------------
// truth_table_extractor
//
// Characterises a 3-input combinational cell. The block steps the cell's
// inputs through all eight combinations, waits a settle time on each one,
// samples the cell output and builds the 8-bit truth-table code. Vector
// {in1,in2,in3} = 000 lands in code[7] and 111 lands in code[0]. The result
// is held under a valid/ack handshake.
//
// Parameters:
//   SETTLE_CYCLES - cycles each vector is held before sampling (2..255)
//   CNT_W         - width of the settle counter, must hold SETTLE_CYCLES
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle sweep request, honoured only when idle
//   busy       - high while a sweep is in progress
//   drv_in1    - cell input in1 (vector MSB)
//   drv_in2    - cell input in2
//   drv_in3    - cell input in3 (vector LSB)
//   dut_out    - cell output, may be asynchronous to clk
//   code       - extracted truth-table code
//   code_valid - code is complete and stable
//   code_ack   - consumer accepts the code
// ---------------------------------------------------------------------------
module truth_table_extractor #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       drv_in1,
   output logic       drv_in2,
   output logic       drv_in3,
   input  logic       dut_out,
   output logic [7:0] code,
   output logic       code_valid,
   input  logic       code_ack
);

   // The synchroniser adds two cycles of delay between a vector change and
   // the sampled output, so fewer than two settle cycles would sample the
   // previous vector's response.
   generate
      if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
         $error("truth_table_extractor: SETTLE_CYCLES must be in 2..255");
      end
      if (SETTLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
         $error("truth_table_extractor: CNT_W too narrow for SETTLE_CYCLES");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [2:0]       idx;
   logic [2:0]       idx_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [7:0]       code_q;
   logic [7:0]       code_next;
   logic             sync_1;
   logic             sync_2;

   // Two-flop synchroniser on the cell output. The cell is driven by our own
   // flops but its output path is treated as asynchronous, so it is never
   // used before passing through both stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= dut_out;
         sync_2 <= sync_1;
      end
   end

   // State register plus the sweep bookkeeping: vector index, settle
   // counter and the code being assembled. All of it returns to zero on
   // reset, so a partially built code can never be presented as valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= 3'd0;
         cnt    <= '0;
         code_q <= 8'h00;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         cnt    <= cnt_next;
         code_q <= code_next;
      end
   end

   // Next-state logic. Each vector spends SETTLE_CYCLES cycles in SETTLE and
   // one cycle in SAMPLE. The index is left at 7 in DONE so the cell keeps
   // seeing 111 until the consumer acknowledges, then drops back to 000.
   // start is only looked at in IDLE, so it is ignored mid-sweep and also
   // loses to code_ack when both arrive in DONE.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      cnt_next   = cnt;
      code_next  = code_q;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SETTLE;
               idx_next   = 3'd0;
               cnt_next   = '0;
               code_next  = 8'h00;
            end
         end
         SETTLE: begin
            if (cnt == CNT_LAST) begin
               state_next = SAMPLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         SAMPLE: begin
            code_next[3'd7 - idx] = sync_2;
            cnt_next              = '0;
            if (idx == 3'd7) begin
               state_next = DONE;
            end else begin
               idx_next   = idx + 3'd1;
               state_next = SETTLE;
            end
         end
         DONE: begin
            if (code_ack) begin
               state_next = IDLE;
               idx_next   = 3'd0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The cell inputs are the index directly; it is 000 whenever idle.
   assign {drv_in1, drv_in2, drv_in3} = idx;
   assign busy       = (state == SETTLE) || (state == SAMPLE);
   assign code_valid = (state == DONE);
   assign code       = code_q;

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Characterisation block for 3-input combinational logic cells in the 8-bit truth-table family.
- Drives all eight input combinations into a device under test (DUT) and waits a programmable settle time per vector.
- Samples the DUT output after each settle time and assembles the 8-bit hex function code, e.g. 0xD5.
- Sits in the bench/characterisation harness beside the gate library and holds the result under a valid/ack handshake.

Parameters:
- SETTLE_CYCLES, 4: cycles each vector is held before sampling. Legal range 2..255; elaboration error outside this range.
- CNT_W, 8: width of the settle counter. Must hold SETTLE_CYCLES.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  output  1  high from start acceptance until code_valid rises.
- drv_in1  output  1  DUT input in1, MSB of the vector.
- drv_in2  output  1  DUT input in2.
- drv_in3  output  1  DUT input in3, LSB of the vector.
- dut_out  input  1  DUT output; may be asynchronous.
- code  output  8  extracted truth-table code.
- code_valid  output  1  code is stable and complete.
- code_ack  input  1  consumer accepts code.

Behaviour:
- Reset (async assert, sync deassert on clk): state=IDLE; busy=0; drv_in1..3=0; code=0x00; code_valid=0; vector index=0; settle counter=0; synchroniser flops=0.
- dut_out passes through a 2-flop synchroniser. The sampled value therefore reflects dut_out from 2 cycles earlier, which is why SETTLE_CYCLES must be at least 2.
- Vector order: idx = {in1,in2,in3} = 0,1,...,7, counting up.
- Code bit mapping: code[7-idx] = sampled output for vector idx. Vector 000 goes to the MSB, vector 111 to the LSB. Example: outputs 000→1, 001→1, 010→0, 011→1, 100→0, 101→1, 110→0, 111→1 give code=0xD5.
- State IDLE:
  - drv_in* hold 000 after reset and after each completed sweep.
  - start=1 → SETTLE next cycle, with idx=0, drv=000, counter=0, busy=1. The code register is cleared to 0x00 at the same time.
- State SETTLE:
  - drv_in* = idx; counter increments each cycle.
  - When counter = SETTLE_CYCLES-1 → SAMPLE.
- State SAMPLE (exactly one cycle):
  - code[7-idx] <= synchronised dut_out.
  - If idx=7 → DONE. Otherwise idx <= idx+1, counter <= 0, → SETTLE.
- Per-vector occupancy: SETTLE_CYCLES+1 cycles. Full sweep: 8*(SETTLE_CYCLES+1) cycles from the first SETTLE cycle.
- State DONE:
  - code_valid=1, busy=0, code frozen. drv_in* keep 111 until the ack.
  - code_ack=1 → IDLE next cycle; code_valid=0; drv_in* return to 000; code keeps its last value.
- code_ack while code_valid=0 is ignored.
- start outside IDLE is ignored: no restart and no queuing. start and code_ack together in DONE: ack is taken, start is dropped.
- Reset mid-sweep: asynchronous return to the reset values. A partial code is never presented as valid.
- No self-timeout. The DUT output is only sampled, never checked.

Test Plan:
- Reset values: rst_n low for 3 cycles, then high → busy=0, code_valid=0, code=0x00, drv=000.
- Function 0xD5: bench model drives dut_out = reference function of drv (000,001,011,101,111 →1; else 0). Pulse start, SETTLE_CYCLES=4 → code_valid rises exactly 40 cycles after the first SETTLE cycle, code=0xD5. drv holds each vector for 5 cycles in order 000..111.
- Constant functions: dut_out tied 0 → code=0x00; tied 1 → code=0xFF. Then repeat with SETTLE_CYCLES=2 → code_valid after 24 cycles.
- Handshake: hold code_ack=0 for 10 cycles after code_valid → code stable, busy=0. Pulse code_ack → code_valid drops next cycle, drv=000. A second sweep on function 0x2A (000→0, 001→0, 010→1, 011→0, 100→1, 101→0, 110→1, 111→0) returns 0x2A.
- Ignored start: pulse start at idx=3 mid-sweep → sweep unaffected, single code_valid, correct code.
- Reset mid-operation: assert rst_n low during the SAMPLE of idx=5 → outputs return to reset values immediately. A new start yields a full, correct code.
